panel_controller: RTL and testbench
===================================

# panel_controller

Front-panel controller sequencing the signal-generator datapath from four raw pushbuttons. It debounces the buttons and detects presses, with hold-to-repeat on the vertical pair. It owns the display-mode register (0–3) and the frequency-control word (1–128) consumed by the wave generator, frequency calculator and display mux. It runs in the 100 kHz domain alongside those blocks.

## Interface
- DEBOUNCE_CYCLES, 2000: consecutive stable cycles required to accept a level change (20 ms).
- REPEAT_DELAY, 50000: hold time before the first auto-repeat (500 ms).
- REPEAT_RATE, 10000: auto-repeat period after REPEAT_DELAY (100 ms).
- clk_100kHz  in  1  sole clock; all logic on the rising edge.
- rst_  in  1  asynchronous, active-low reset.
- h_pb  in  2  raw, asynchronous buttons; [1]=mode up, [0]=mode down.
- v_pb  in  2  raw, asynchronous buttons; [0]=freq up, [1]=freq down.
- mode  out  2  display mode; 0=ID, 1=freq_ctrl, 2=theory freq, 3=measured freq.
- freq_ctrl  out  8  frequency-control word, range 1..128.
- mode_chg  out  1  one-cycle pulse on the cycle `mode` takes a new value.
- freq_chg  out  1  one-cycle pulse on the cycle `freq_ctrl` takes a new value.

## Operation
- Each button path: 2-flop synchronizer, then debouncer.
  - `stable` flips only after the synchronized input has differed from it for DEBOUNCE_CYCLES consecutive cycles.
  - Any cycle of agreement clears the counter.
- Press event: one-cycle pulse on the 0→1 transition of `stable`. Releases generate no event.
- Horizontal buttons: press events only, no repeat.
- Vertical buttons: per-button repeat FSM.
  - IDLE → HELD on a press event.
  - HELD counts REPEAT_DELAY cycles, then goes to RPT and emits an event.
  - RPT emits an event every REPEAT_RATE cycles.
  - Any state goes to IDLE when `stable` falls.
- If both vertical buttons are `stable`=1, both FSMs are forced to IDLE and emit nothing.
- Mode update:
  - up event and mode<3: mode+1.
  - down event and mode>0: mode−1.
  - Saturates at the ends; saturated presses produce no mode_chg.
- Freq update:
  - up event: +1, wrapping 128→1.
  - down event: −1, wrapping 1→128.
  - Every accepted event asserts freq_chg.
- Simultaneous opposing events in one cycle (h up+down, or v up+down) cancel: no change, no pulse.
- A mode event and a freq event in the same cycle are both applied.
- Arithmetic is 8-bit. Values 0 and 129..255 are unreachable. freq_ctrl is never 0.

## Timing
- Reset values:
  - mode=0, freq_ctrl=1, mode_chg=0, freq_chg=0.
  - Synchronizers, `stable`, counters 0; FSMs in IDLE.
- Latency: a raw 0→1 level first sampled at edge N updates mode/freq_ctrl, with its pulse, at edge N+DEBOUNCE_CYCLES+3.
  - 2 cycles synchronizer, DEBOUNCE_CYCLES debounce, 1 cycle register.
- Repeat cadence, measured from the first register update:
  - second update at +REPEAT_DELAY cycles;
  - then one update every REPEAT_RATE cycles.
- Pulses are exactly one cycle wide and coincide with the register change.
- Bounce shorter than DEBOUNCE_CYCLES produces no event.
- Reset asserted mid-hold: all state clears immediately. A button still held after release is re-debounced and counts as a new press.
- Outputs are registered, with no combinational path from input to output.

## Structure
- Shared package/header `panel_pkg`:
  - MODE_ID=0, MODE_CTRL=1, MODE_THEORY=2, MODE_MEASURED=3.
  - FREQ_MIN=8'd1, FREQ_MAX=8'd128.
  - Default timing constants.
- Sub-module `pb_debounce`: synchronizer, debounce counter, `stable` and `press` outputs. Four instances.
- Repeat FSMs and the mode/freq registers live in the top of this block.

## Test plan
Simulation uses DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=5.
- Reset, then idle 50 cycles → mode=0, freq_ctrl=1, no pulses.
- h_pb[1] held for 4 separate presses → mode 1,2,3,3. The fourth press gives no mode_chg. Update occurs 7 cycles after first sample.
- v_pb[1] press at freq_ctrl=1 → 128. v_pb[0] press at 128 → 1. freq_chg on each.
- v_pb[0] held 40 cycles from freq_ctrl=10 → updates at t, t+20, t+25, t+30, t+35 → 15. Stops on release.
- Bounce (3-cycle pulses, 2-cycle gaps) on h_pb[0] → no event. Both v buttons pressed in the same cycle → no change, no pulse.
- rst_ low for 2 cycles while v_pb[0] held at freq_ctrl=50 → freq_ctrl=1 immediately. After release, one press becomes 2 after 7 cycles.

Source files
------------

// File: rtl/panel_pkg.sv
// Shared constants for the front-panel controller: display modes, frequency-word
// limits, default timing and the repeat-FSM encoding.
package panel_pkg;

    localparam logic [1:0] MODE_ID       = 2'd0;
    localparam logic [1:0] MODE_CTRL     = 2'd1;
    localparam logic [1:0] MODE_THEORY   = 2'd2;
    localparam logic [1:0] MODE_MEASURED = 2'd3;

    localparam logic [7:0] FREQ_MIN = 8'd1;
    localparam logic [7:0] FREQ_MAX = 8'd128;

    // Defaults at 100 kHz: 20 ms debounce, 500 ms repeat delay, 100 ms repeat period
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 2000;
    localparam int unsigned DEF_REPEAT_DELAY    = 50000;
    localparam int unsigned DEF_REPEAT_RATE     = 10000;

    localparam logic [1:0] RPT_IDLE = 2'd0;
    localparam logic [1:0] RPT_HELD = 2'd1;
    localparam logic [1:0] RPT_RPT  = 2'd2;

    // Probe point for the two vertical-button repeat FSMs
    typedef struct packed {
        logic [1:0] up_state;
        logic [1:0] dn_state;
        logic [1:0] v_stable;
    } rpt_dbg_t;

    // One step of the frequency word, wrapping 128->1 going up and 1->128 going down
    function automatic logic [7:0] freq_step(input logic [7:0] f, input logic up);
        logic [7:0] r;
        if (up) begin
            r = (f >= FREQ_MAX) ? FREQ_MIN : f + 8'd1;
        end else begin
            r = (f <= FREQ_MIN) ? FREQ_MAX : f - 8'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pb_debounce.sv
// One pushbutton path: 2-flop synchronizer, consecutive-cycle debouncer and a
// registered press pulse on each accepted 0->1 transition.
module pb_debounce
    import panel_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_,
    input  logic raw,
    output logic stable,
    output logic press
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             stable_q, stable_d;
    logic             stable_dly_q, stable_dly_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d      = raw;
        sync2_d      = sync1_q;
        stable_d     = stable_q;
        cnt_d        = '0;
        stable_dly_d = stable_q;
        press_d      = stable_q & ~stable_dly_q;
        // cnt_q holds how many consecutive disagreeing cycles have already been seen
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = ~stable_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            stable_q     <= 1'b0;
            stable_dly_q <= 1'b0;
            press_q      <= 1'b0;
            cnt_q        <= '0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            stable_q     <= stable_d;
            stable_dly_q <= stable_dly_d;
            press_q      <= press_d;
            cnt_q        <= cnt_d;
        end
    end

    assign stable = stable_q;
    assign press  = press_q;

endmodule

// File: rtl/panel_controller.sv
// Front-panel controller: debounced buttons, hold-to-repeat on the vertical pair,
// and the display-mode / frequency-control registers with change pulses.
module panel_controller
    import panel_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_RATE     = DEF_REPEAT_RATE
) (
    input  logic       clk_100kHz,
    input  logic       rst_,
    input  logic [1:0] h_pb,
    input  logic [1:0] v_pb,
    output logic [1:0] mode,
    output logic [7:0] freq_ctrl,
    output logic       mode_chg,
    output logic       freq_chg
);

    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
    localparam logic [RPT_W-1:0] RD_LAST = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RR_LAST = RPT_W'(REPEAT_RATE - 1);

    logic [1:0] h_stable, h_press;
    logic [1:0] v_stable, v_press;

    for (genvar g = 0; g < 2; g++) begin : g_db
        pb_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_h (
            .clk    (clk_100kHz),
            .rst_   (rst_),
            .raw    (h_pb[g]),
            .stable (h_stable[g]),
            .press  (h_press[g])
        );
        pb_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_v (
            .clk    (clk_100kHz),
            .rst_   (rst_),
            .raw    (v_pb[g]),
            .stable (v_stable[g]),
            .press  (v_press[g])
        );
    end

    // Index 0 is the freq-up button, index 1 the freq-down button
    logic [1:0][1:0]       rpt_state_q, rpt_state_d;
    logic [1:0][RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic [1:0]            v_event;
    logic                  both_held;

    always_comb begin
        both_held   = v_stable[0] & v_stable[1];
        rpt_state_d = rpt_state_q;
        rpt_cnt_d   = rpt_cnt_q;
        v_event     = '0;
        for (int i = 0; i < 2; i++) begin
            if (both_held || !v_stable[i]) begin
                rpt_state_d[i] = RPT_IDLE;
                rpt_cnt_d[i]   = '0;
            end else begin
                case (rpt_state_q[i])
                    RPT_IDLE: begin
                        if (v_press[i]) begin
                            v_event[i]     = 1'b1;
                            rpt_state_d[i] = RPT_HELD;
                            rpt_cnt_d[i]   = '0;
                        end
                    end
                    RPT_HELD: begin
                        if (rpt_cnt_q[i] == RD_LAST) begin
                            v_event[i]     = 1'b1;
                            rpt_state_d[i] = RPT_RPT;
                            rpt_cnt_d[i]   = '0;
                        end else begin
                            rpt_cnt_d[i] = rpt_cnt_q[i] + 1'b1;
                        end
                    end
                    RPT_RPT: begin
                        if (rpt_cnt_q[i] == RR_LAST) begin
                            v_event[i]   = 1'b1;
                            rpt_cnt_d[i] = '0;
                        end else begin
                            rpt_cnt_d[i] = rpt_cnt_q[i] + 1'b1;
                        end
                    end
                    default: begin
                        rpt_state_d[i] = RPT_IDLE;
                        rpt_cnt_d[i]   = '0;
                    end
                endcase
            end
        end
    end

    logic [1:0] mode_q, mode_d;
    logic [7:0] freq_q, freq_d;
    logic       mode_chg_q, mode_chg_d;
    logic       freq_chg_q, freq_chg_d;

    // Opposing events in the same cycle cancel; saturated mode presses are ignored
    always_comb begin
        mode_d     = mode_q;
        mode_chg_d = 1'b0;
        freq_d     = freq_q;
        freq_chg_d = 1'b0;
        if (h_press[1] && !h_press[0] && mode_q != MODE_MEASURED) begin
            mode_d     = mode_q + 2'd1;
            mode_chg_d = 1'b1;
        end else if (h_press[0] && !h_press[1] && mode_q != MODE_ID) begin
            mode_d     = mode_q - 2'd1;
            mode_chg_d = 1'b1;
        end
        if (v_event[0] != v_event[1]) begin
            freq_d     = freq_step(freq_q, v_event[0]);
            freq_chg_d = 1'b1;
        end
    end

    always_ff @(posedge clk_100kHz or negedge rst_) begin
        if (!rst_) begin
            rpt_state_q <= {RPT_IDLE, RPT_IDLE};
            rpt_cnt_q   <= '0;
            mode_q      <= MODE_ID;
            freq_q      <= FREQ_MIN;
            mode_chg_q  <= 1'b0;
            freq_chg_q  <= 1'b0;
        end else begin
            rpt_state_q <= rpt_state_d;
            rpt_cnt_q   <= rpt_cnt_d;
            mode_q      <= mode_d;
            freq_q      <= freq_d;
            mode_chg_q  <= mode_chg_d;
            freq_chg_q  <= freq_chg_d;
        end
    end

    assign mode      = mode_q;
    assign freq_ctrl = freq_q;
    assign mode_chg  = mode_chg_q;
    assign freq_chg  = freq_chg_q;

    // rpt_dbg is a bind point for checkers; the horizontal stable levels have no consumer
    rpt_dbg_t rpt_dbg;
    logic     unused_sink;
    assign rpt_dbg.up_state = rpt_state_q[0];
    assign rpt_dbg.dn_state = rpt_state_q[1];
    assign rpt_dbg.v_stable = v_stable;
    assign unused_sink      = ^{h_stable, rpt_dbg};

endmodule

// File: tb/tb_panel_controller.sv
// Directed bench for panel_controller with short timing constants
// (debounce 4, repeat delay 20, repeat rate 5).
module tb_panel_controller;
    import panel_pkg::*;

    logic       clk = 1'b0;
    logic       rst_;
    logic [1:0] h_pb;
    logic [1:0] v_pb;
    logic [1:0] mode;
    logic [7:0] freq_ctrl;
    logic       mode_chg;
    logic       freq_chg;

    int n_checks = 0;
    int n_errors = 0;
    int mode_chg_cnt = 0;
    int freq_chg_cnt = 0;
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];

    always #5 clk = ~clk;

    panel_controller #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (20),
        .REPEAT_RATE     (5)
    ) dut (
        .clk_100kHz (clk),
        .rst_       (rst_),
        .h_pb       (h_pb),
        .v_pb       (v_pb),
        .mode       (mode),
        .freq_ctrl  (freq_ctrl),
        .mode_chg   (mode_chg),
        .freq_chg   (freq_chg)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock and sample just after the edge
    task automatic tick();
        @(posedge clk);
        #1;
        mode_chg_cnt += int'(mode_chg);
        freq_chg_cnt += int'(freq_chg);
    endtask

    task automatic tap(input logic [1:0] h, input logic [1:0] v);
        h_pb = h;
        v_pb = v;
        repeat (10) tick();
        h_pb = 2'b00;
        v_pb = 2'b00;
        repeat (12) tick();
    endtask

    initial begin
        rst_ = 1'b0;
        h_pb = 2'b00;
        v_pb = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mode", 32'(mode), 32'(MODE_ID));
        check("rst_freq", 32'(freq_ctrl), 32'd1);
        check("rst_mode_chg", 32'(mode_chg), 32'd0);
        check("rst_freq_chg", 32'(freq_chg), 32'd0);
        rst_ = 1'b1;

        mode_chg_cnt = 0;
        freq_chg_cnt = 0;
        repeat (50) tick();
        check("idle_mode", 32'(mode), 32'd0);
        check("idle_freq", 32'(freq_ctrl), 32'd1);
        check("idle_pulses", 32'(mode_chg_cnt + freq_chg_cnt), 32'd0);

        // Mode up: first sample at tick 1, update lands on tick 8
        h_pb = 2'b10;
        repeat (7) tick();
        check("lat_mode_before", 32'(mode), 32'd0);
        check("lat_chg_before", 32'(mode_chg), 32'd0);
        tick();
        check("lat_mode", 32'(mode), 32'(MODE_CTRL));
        check("lat_chg", 32'(mode_chg), 32'd1);
        tick();
        check("lat_chg_width", 32'(mode_chg), 32'd0);
        tick();
        h_pb = 2'b00;
        repeat (12) tick();

        mode_chg_cnt = 0;
        tap(2'b10, 2'b00);
        check("mode_2", 32'(mode), 32'(MODE_THEORY));
        tap(2'b10, 2'b00);
        check("mode_3", 32'(mode), 32'(MODE_MEASURED));
        tap(2'b10, 2'b00);
        check("mode_sat", 32'(mode), 32'(MODE_MEASURED));
        check("mode_sat_pulses", 32'(mode_chg_cnt), 32'd2);

        // Long hold on mode-down must not repeat
        mode_chg_cnt = 0;
        h_pb = 2'b01;
        repeat (60) tick();
        h_pb = 2'b00;
        repeat (12) tick();
        check("h_norepeat_mode", 32'(mode), 32'(MODE_THEORY));
        check("h_norepeat_pulses", 32'(mode_chg_cnt), 32'd1);

        mode_chg_cnt = 0;
        tap(2'b11, 2'b00);
        check("h_cancel_mode", 32'(mode), 32'(MODE_THEORY));
        check("h_cancel_pulses", 32'(mode_chg_cnt), 32'd0);

        mode_chg_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            h_pb = 2'b01;
            repeat (3) tick();
            h_pb = 2'b00;
            repeat (2) tick();
        end
        repeat (12) tick();
        check("bounce_mode", 32'(mode), 32'(MODE_THEORY));
        check("bounce_pulses", 32'(mode_chg_cnt), 32'd0);

        freq_chg_cnt = 0;
        tap(2'b00, 2'b10);
        check("wrap_down", 32'(freq_ctrl), 32'd128);
        tap(2'b00, 2'b01);
        check("wrap_up", 32'(freq_ctrl), 32'd1);
        check("wrap_pulses", 32'(freq_chg_cnt), 32'd2);

        mode_chg_cnt = 0;
        freq_chg_cnt = 0;
        tap(2'b10, 2'b01);
        check("both_kinds_mode", 32'(mode), 32'(MODE_MEASURED));
        check("both_kinds_freq", 32'(freq_ctrl), 32'd2);
        check("both_kinds_pulses", 32'(mode_chg_cnt + freq_chg_cnt), 32'd2);

        for (int i = 0; i < 8; i++) tap(2'b00, 2'b01);
        check("freq_10", 32'(freq_ctrl), 32'd10);

        // Hold freq-up for 40 sampled cycles: updates at ticks 8, 28, 33, 38, 43
        exp_q.push_back(32'd8);
        exp_q.push_back(32'd28);
        exp_q.push_back(32'd33);
        exp_q.push_back(32'd38);
        exp_q.push_back(32'd43);
        v_pb = 2'b01;
        for (int c = 1; c <= 70; c++) begin
            tick();
            if (freq_chg === 1'b1) got_q.push_back(32'(c));
            if (c == 40) v_pb = 2'b00;
        end
        check("rpt_count", 32'(got_q.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            check("rpt_time", got_q.pop_front(), exp_q.pop_front());
        end
        check("rpt_freq", 32'(freq_ctrl), 32'd15);

        // Second vertical button joining mid-hold stops the repeat for good
        freq_chg_cnt = 0;
        v_pb = 2'b01;
        repeat (10) tick();
        v_pb = 2'b11;
        repeat (40) tick();
        v_pb = 2'b01;
        repeat (40) tick();
        v_pb = 2'b00;
        repeat (12) tick();
        check("overlap_freq", 32'(freq_ctrl), 32'd16);
        check("overlap_pulses", 32'(freq_chg_cnt), 32'd1);

        freq_chg_cnt = 0;
        v_pb = 2'b11;
        repeat (40) tick();
        v_pb = 2'b00;
        repeat (12) tick();
        check("v_both_freq", 32'(freq_ctrl), 32'd16);
        check("v_both_pulses", 32'(freq_chg_cnt), 32'd0);

        for (int i = 0; i < 33; i++) tap(2'b00, 2'b01);
        check("freq_49", 32'(freq_ctrl), 32'd49);

        v_pb = 2'b01;
        repeat (12) tick();
        check("hold_freq_50", 32'(freq_ctrl), 32'd50);
        rst_ = 1'b0;
        #1;
        check("async_rst_freq", 32'(freq_ctrl), 32'd1);
        check("async_rst_mode", 32'(mode), 32'd0);
        repeat (2) tick();
        rst_ = 1'b1;
        repeat (7) tick();
        check("rerun_before", 32'(freq_ctrl), 32'd1);
        tick();
        check("rerun_freq", 32'(freq_ctrl), 32'd2);
        check("rerun_chg", 32'(freq_chg), 32'd1);
        v_pb = 2'b00;
        repeat (12) tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
